// File: rtl/paddle_ctrl.sv
// Paddle position controller: queues mouse up/down requests, applies one STEP per video frame.
// Latency: paddle_y and the pending count update on the same edge that samples frame_tick/valid.
// No backpressure: requests beyond +/-PEND_MAX are dropped and flagged by a one-cycle sat pulse.
module paddle_ctrl #(
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 416,
  parameter int Y_INIT   = 208,
  parameter int STEP     = 8,
  parameter int PEND_MAX = 7
) (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       upr,
  input  logic       downr,
  input  logic       valid,
  input  logic       frame_tick,
  output logic [9:0] paddle_y,
  output logic       busy,
  output logic       at_top,
  output logic       at_bottom,
  output logic       sat
);

  // Pending count width: magnitude bits plus sign bit.
  localparam int PW = $clog2(PEND_MAX + 1) + 1;
  localparam int YMS = Y_MIN + STEP;

  // Position math is done in 11 bits so y-STEP / y+STEP never wraps.
  localparam logic [10:0] LP_Y_MIN      = Y_MIN[10:0];
  localparam logic [10:0] LP_Y_MAX      = Y_MAX[10:0];
  localparam logic [10:0] LP_STEP       = STEP[10:0];
  localparam logic [10:0] LP_Y_MIN_STEP = YMS[10:0];
  localparam logic [9:0]  LP_Y_INIT     = Y_INIT[9:0];
  localparam logic [9:0]  LP_Y_MIN10    = Y_MIN[9:0];
  localparam logic [9:0]  LP_Y_MAX10    = Y_MAX[9:0];

  // One extra bit of headroom for the unsaturated next-count sum.
  localparam logic signed [PW:0]   LP_PMAX  = PEND_MAX[PW:0];
  localparam logic signed [PW:0]   LP_PMIN  = -LP_PMAX;
  localparam logic signed [PW:0]   LP_ONE   = 1;
  localparam logic signed [PW:0]   LP_ZERO1 = '0;
  localparam logic signed [PW-1:0] LP_ZERO  = '0;

  logic signed [PW-1:0] r_pend;
  logic [9:0]           r_y;
  logic                 r_sat;

  logic                 w_req_up;
  logic                 w_req_dn;
  logic                 w_cons_up;
  logic                 w_cons_dn;
  logic [10:0]          w_y_ext;
  logic [10:0]          w_y_nxt;
  logic                 w_wall_hit;
  logic signed [PW:0]   w_base;
  logic signed [PW:0]   w_sum;
  logic signed [PW-1:0] w_pend_nxt;
  logic                 w_sat_nxt;

  // Decode request/consume, compute clamped next position and saturated next count.
  always_comb begin
    w_req_up   = valid & upr & ~downr;
    w_req_dn   = valid & downr & ~upr;
    w_cons_up  = frame_tick & (r_pend > LP_ZERO);
    w_cons_dn  = frame_tick & r_pend[PW-1];
    w_y_ext    = {1'b0, r_y};
    w_y_nxt    = w_y_ext;
    w_wall_hit = 1'b0;

    if (w_cons_up) begin
      if (w_y_ext < LP_Y_MIN_STEP) w_y_nxt = LP_Y_MIN;
      else                         w_y_nxt = w_y_ext - LP_STEP;
      // Arriving at the wall discards owed moves; already being there just consumes one.
      w_wall_hit = (w_y_nxt == LP_Y_MIN) && (w_y_ext != LP_Y_MIN);
    end else if (w_cons_dn) begin
      if (w_y_ext + LP_STEP > LP_Y_MAX) w_y_nxt = LP_Y_MAX;
      else                              w_y_nxt = w_y_ext + LP_STEP;
      w_wall_hit = (w_y_nxt == LP_Y_MAX) && (w_y_ext != LP_Y_MAX);
    end

    // Consume first (or clear on wall hit), then apply this cycle's request.
    w_base = {r_pend[PW-1], r_pend};
    if (w_wall_hit)     w_base = LP_ZERO1;
    else if (w_cons_up) w_base = w_base - LP_ONE;
    else if (w_cons_dn) w_base = w_base + LP_ONE;

    w_sum = w_base;
    if (w_req_up)      w_sum = w_base + LP_ONE;
    else if (w_req_dn) w_sum = w_base - LP_ONE;

    w_sat_nxt  = 1'b0;
    w_pend_nxt = w_sum[PW-1:0];
    if (w_sum > LP_PMAX) begin
      w_pend_nxt = LP_PMAX[PW-1:0];
      w_sat_nxt  = 1'b1;
    end else if (w_sum < LP_PMIN) begin
      w_pend_nxt = LP_PMIN[PW-1:0];
      w_sat_nxt  = 1'b1;
    end
  end

  // Register position, pending count and saturation pulse.
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      r_y    <= LP_Y_INIT;
      r_pend <= LP_ZERO;
      r_sat  <= 1'b0;
    end else begin
      r_y    <= w_y_nxt[9:0];
      r_pend <= w_pend_nxt;
      r_sat  <= w_sat_nxt;
    end
  end

  assign paddle_y  = r_y;
  assign busy      = (r_pend != LP_ZERO);
  assign at_top    = (r_y == LP_Y_MIN10);
  assign at_bottom = (r_y == LP_Y_MAX10);
  assign sat       = r_sat;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: default instance plus a second one starting near the top wall.
module tb_paddle_ctrl;

  logic       clk_12MHz = 1'b0;
  logic       reset;
  logic       upr, downr, valid, frame_tick;
  logic [9:0] y1, y2;
  logic       busy1, busy2, top1, top2, bot1, bot2, sat1, sat2;

  int checks = 0;
  int errors = 0;

  always #5 clk_12MHz = ~clk_12MHz;

  paddle_ctrl u_dut (
    .clk_12MHz(clk_12MHz), .reset(reset), .upr(upr), .downr(downr),
    .valid(valid), .frame_tick(frame_tick), .paddle_y(y1), .busy(busy1),
    .at_top(top1), .at_bottom(bot1), .sat(sat1)
  );

  paddle_ctrl #(.Y_INIT(4)) u_dut2 (
    .clk_12MHz(clk_12MHz), .reset(reset), .upr(upr), .downr(downr),
    .valid(valid), .frame_tick(frame_tick), .paddle_y(y2), .busy(busy2),
    .at_top(top2), .at_bottom(bot2), .sat(sat2)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic u, input logic d, input logic v, input logic t);
    @(negedge clk_12MHz);
    upr = u; downr = d; valid = v; frame_tick = t;
    @(posedge clk_12MHz);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_12MHz);
    upr = 0; downr = 0; valid = 0; frame_tick = 0;
    reset = 1;
    @(negedge clk_12MHz);
    reset = 0;
  endtask

  function automatic logic signed [31:0] p1();
    return 32'($signed(u_dut.r_pend));
  endfunction

  function automatic logic signed [31:0] p2();
    return 32'($signed(u_dut2.r_pend));
  endfunction

  initial begin
    upr = 0; downr = 0; valid = 0; frame_tick = 0;
    reset = 1;
    #12;
    // Reset state
    check("rst_y", y1, 208);
    check("rst_busy", busy1, 0);
    check("rst_sat", sat1, 0);
    check("rst_top", top1, 0);
    check("rst_bot", bot1, 0);
    check("rst_p", p1(), 0);
    check("rst_y2", y2, 4);
    @(negedge clk_12MHz);
    reset = 0;

    // Three up requests then three frame ticks
    step(1, 0, 1, 0); check("up1_p", p1(), 1);
    step(1, 0, 1, 0); check("up2_p", p1(), 2);
    step(1, 0, 1, 0); check("up3_p", p1(), 3);
    check("up3_busy", busy1, 1);
    step(0, 0, 0, 1); check("t1_y", y1, 200); check("t1_busy", busy1, 1);
    step(0, 0, 0, 1); check("t2_y", y1, 192); check("t2_busy", busy1, 1);
    step(0, 0, 0, 1); check("t3_y", y1, 184); check("t3_busy", busy1, 0);

    // Asynchronous reset between edges while P=+5
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    check("pre_arst_p", p1(), 5);
    check("pre_arst_y", y1, 184);
    #2 reset = 1;
    #1;
    check("arst_y", y1, 208);
    check("arst_busy", busy1, 0);
    check("arst_p", p1(), 0);
    @(negedge clk_12MHz);
    reset = 0;

    // Ten down requests: saturate at -7, sat on requests 8..10
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 1, 0);
      check($sformatf("dn%0d_sat", i), sat1, (i >= 8) ? 1 : 0);
      check($sformatf("dn%0d_p", i), p1(), (i >= 7) ? -7 : -i);
    end
    step(0, 0, 0, 0);
    check("sat_clear", sat1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
    check("dn_ticks_y", y1, 264);
    check("dn_ticks_busy", busy1, 0);

    // Invalid request patterns leave P alone
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0); check("both_p", p1(), 2); check("both_sat", sat1, 0);
    step(0, 0, 1, 0); check("none_p", p1(), 2); check("none_sat", sat1, 0);
    step(1, 0, 0, 0); check("novalid_p", p1(), 2);

    // Request and tick in the same cycle
    do_reset();
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    check("same_y", y1, 200);
    check("same_p", p1(), 1);

    // Bottom wall: clamp, discard owed moves, then consume at the wall
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
    end
    check("bot_y", y1, 416);
    check("bot_flag", bot1, 1);
    check("bot_busy", busy1, 0);
    step(0, 1, 1, 0); check("bot_req_p", p1(), -1);
    step(0, 0, 0, 1);
    check("bot_cons_y", y1, 416);
    check("bot_cons_p", p1(), 0);

    // Top wall on the second instance: y=4, P=+3, one tick
    do_reset();
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    check("top_pre_p", p2(), 3);
    step(0, 0, 0, 1);
    check("top_y", y2, 0);
    check("top_flag", top2, 1);
    check("top_p", p2(), 0);
    check("top_busy", busy2, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 1);
    check("top_cons_y", y2, 0);
    check("top_cons_p", p2(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
